// File: rtl/pool2x2_stream.sv
// pool2x2_stream
//   Non-overlapping 2x2 pooling over a DIM x DIM matrix that arrives row-major,
//   one word per din_valid beat. Produces a (DIM/2)x(DIM/2) row-major result
//   stream. Only a DIM/2-entry line buffer of partial window results is kept.
//
//   Build option: define POOL_AVG_EN for average pooling (window sum >> 2,
//   truncating). Left undefined, the block does unsigned max pooling.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse arming a new frame (restarts a running one)
//   din_valid  din holds a matrix element this cycle
//   din        matrix element, unsigned DW bits
//   dout_valid single-cycle pulse: dout holds a new pooled result
//   dout       pooled result, held between pulses
//   busy       a frame is armed and in progress
//   doneP      pulse coincident with the final result of a frame
module pool2x2_stream #(
  parameter int DW  = 16,
  parameter int DIM = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  output logic          dout_valid,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          doneP
);

  localparam int CW = $clog2(DIM);
  localparam int NL = DIM / 2;
  localparam int IW = (NL > 1) ? $clog2(NL) : 1;
`ifdef POOL_AVG_EN
  // hold carries up to three summed words, line buffer up to two
  localparam int HW = DW + 2;
  localparam int LW = DW + 1;
`else
  localparam int HW = DW;
  localparam int LW = DW;
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   row, col;
  logic [HW-1:0]   hold;
  logic [LW-1:0]   lb [NL];
  logic            at_last, accept;
  logic [IW-1:0]   idx;
  logic [HW-1:0]   din_x, src, merged;

  // Combine a partial window value with a new element.
  function automatic logic [HW-1:0] f_merge(input logic [HW-1:0] a,
                                            input logic [HW-1:0] b);
`ifdef POOL_AVG_EN
    return a + b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  // Reduce the completed window value to an output word.
  function automatic logic [DW-1:0] f_final(input logic [HW-1:0] s);
`ifdef POOL_AVG_EN
    return DW'(s >> 2);
`else
    return DW'(s);
`endif
  endfunction

  assign at_last = (row == CW'(DIM - 1)) && (col == CW'(DIM - 1));
  // start drops a coincident word, except the very last word of a frame,
  // which still completes so its result is emitted.
  assign accept  = (state == RUN) && din_valid && (!start || at_last);
  assign idx     = IW'(col >> 1);
  assign din_x   = HW'(din);
  // Odd row, even column pulls the upper-row partial from the line buffer;
  // every other combining position continues from hold.
  assign src     = (row[0] && !col[0]) ? HW'(lb[idx]) : hold;
  assign merged  = f_merge(src, din_x);
  assign busy    = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (start)                   state_nxt = RUN;
        else if (accept && at_last)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      hold       <= '0;
      for (int i = 0; i < NL; i++) lb[i] <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
      doneP      <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      doneP      <= 1'b0;

      if (start) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col == CW'(DIM - 1)) begin
          col <= '0;
          row <= (row == CW'(DIM - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // Window accumulation; result registered one cycle after 4th element
      if (accept) begin
        case ({row[0], col[0]})
          2'b00: hold    <= din_x;
          2'b01: lb[idx] <= LW'(merged);
          2'b10: hold    <= merged;
          default: begin
            dout       <= f_final(merged);
            dout_valid <= 1'b1;
            doneP      <= at_last;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
module tb_pool2x2_stream;
  localparam int DW  = 16;
  localparam int DIM = 14;
  localparam int NW  = DIM * DIM;
  localparam int NR  = (DIM / 2) * (DIM / 2);
`ifdef POOL_AVG_EN
  localparam int RAMP_OFF = 7;
`else
  localparam int RAMP_OFF = 15;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, din_valid;
  logic [DW-1:0] din, dout;
  logic          dout_valid, busy, doneP;

  always #5 clk = ~clk;

  pool2x2_stream #(.DW(DW), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din_valid(din_valid), .din(din),
    .dout_valid(dout_valid), .dout(dout), .busy(busy), .doneP(doneP)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mat  [NW];
  logic [DW-1:0] stim [NW];
  logic [DW-1:0] got  [$];
  bit            armed = 1'b0;
  int            n = 0;
  logic [DW-1:0] m_dout = '0;

  // Reference pooling of one 2x2 window from the specification's rule
  function automatic logic [DW-1:0] pool4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c, input logic [DW-1:0] d);
`ifdef POOL_AVG_EN
    logic [DW+1:0] s;
    s = (DW+2)'(a) + (DW+2)'(b) + (DW+2)'(c) + (DW+2)'(d);
    return s[DW+1:2];
`else
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict from the frame model, drive, then check outputs
  task automatic cyc(input logic st, input logic dv, input logic [DW-1:0] d);
    bit            acc, ev, ed;
    logic [DW-1:0] exd;
    int            r, c;
    ev  = 1'b0;
    ed  = 1'b0;
    exd = m_dout;
    acc = armed && dv && (!st || n == NW - 1);
    if (acc) begin
      mat[n] = d;
      r = n / DIM;
      c = n % DIM;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        exd = pool4(mat[n-DIM-1], mat[n-DIM], mat[n-1], mat[n]);
        ev  = 1'b1;
        ed  = (n == NW - 1);
      end
      n++;
      if (n == NW) begin
        armed = 1'b0;
        n     = 0;
      end
    end
    if (st) begin
      armed = 1'b1;
      n     = 0;
    end
    start     = st;
    din_valid = dv;
    din       = d;
    @(posedge clk);
    #1;
    m_dout = exd;
    chk("dout_valid", 32'(dout_valid), 32'(ev));
    chk("dout", 32'(dout), 32'(exd));
    chk("doneP", 32'(doneP), 32'(ed));
    chk("busy", 32'(busy), 32'(armed));
    if (dout_valid) got.push_back(dout);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    start     = 1'(($urandom) & 1);
    din_valid = 1'b1;
    din       = DW'($urandom);
    @(posedge clk);
    #1;
    armed  = 1'b0;
    n      = 0;
    m_dout = '0;
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_doneP", 32'(doneP), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic arm();
    got.delete();
    cyc(1'b1, 1'b0, DW'($urandom));
  endtask

  // gap < 0: random 0..3 idle cycles before each beat
  task automatic send(input int gap, input bit restart_last);
    int g;
    for (int i = 0; i < NW; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) cyc(1'b0, 1'b0, DW'($urandom));
      cyc(restart_last && (i == NW - 1), 1'b1, stim[i]);
    end
  endtask

  task automatic ramp_check(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(NR));
    for (int k = 0; k < got.size() && k < NR; k++)
      chk(tag, 32'(got[k]), 32'(28 * (k / 7) + 2 * (k % 7) + RAMP_OFF));
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) cyc(1'b0, 1'b0, DW'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; din_valid = 1'b0; din = '0;
    do_reset();
    do_reset();

    // Beats without start are ignored
    got.delete();
    repeat (6) cyc(1'b0, 1'b1, DW'($urandom));
    chk("idle_no_output", 32'(got.size()), 32'd0);

    // Ramp, back-to-back
    for (int i = 0; i < NW; i++) stim[i] = DW'(i);
    arm();
    send(0, 1'b0);
    ramp_check("ramp");
    idle(3);

    // Ramp, one beat every third cycle
    arm();
    send(2, 1'b0);
    ramp_check("ramp_gap3");
    idle(2);

    // Extremes
    for (int i = 0; i < NW; i++) stim[i] = '0;
    stim[1*DIM+1]   = 16'hFFFF;
    stim[NW-1]      = 16'h8000;
    arm();
    send(-1, 1'b0);
    chk("ext_count", 32'(got.size()), 32'(NR));
    if (got.size() == NR) begin
`ifdef POOL_AVG_EN
      chk("ext_first", 32'(got[0]), 32'h3FFF);
      chk("ext_last", 32'(got[NR-1]), 32'h2000);
`else
      chk("ext_first", 32'(got[0]), 32'hFFFF);
      chk("ext_last", 32'(got[NR-1]), 32'h8000);
`endif
      for (int k = 1; k < NR - 1; k++) chk("ext_zero", 32'(got[k]), 32'd0);
    end
    idle(2);

    // Abort by start mid-frame, with a coincident word that must be dropped
    for (int i = 0; i < NW; i++) stim[i] = DW'(i);
    arm();
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, stim[i]);
    got.delete();
    cyc(1'b1, 1'b1, 16'hABCD);
    send(0, 1'b0);
    ramp_check("abort");
    idle(2);

    // Reset mid-frame, then beats without start
    arm();
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, stim[i]);
    do_reset();
    got.delete();
    repeat (20) cyc(1'b0, 1'b1, DW'($urandom));
    chk("rst_mid_no_output", 32'(got.size()), 32'd0);

    // start coincident with the last word of a frame
    arm();
    send(0, 1'b1);
    ramp_check("restart_last");
    chk("restart_last_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NW; i++) stim[i] = DW'($urandom);
    got.delete();
    send(-1, 1'b0);
    chk("rearmed_count", 32'(got.size()), 32'(NR));
    idle(2);

    // Random frames with random gaps
    repeat (2) begin
      for (int i = 0; i < NW; i++) stim[i] = DW'($urandom);
      arm();
      send(-1, 1'b0);
      chk("rand_count", 32'(got.size()), 32'(NR));
      idle(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
